// File: rtl/demux4_8_if.sv
// Nibble-in / word-out bus for the half-word reassembler.
// The master drives halves and consumes words; the slave is the reassembler.
interface demux4_8_if #(
  parameter int SIZE = 4
);
  logic [SIZE-1:0]   in;
  logic              sel;
  logic              in_valid;
  logic              in_ready;
  logic              flush;
  logic [2*SIZE-1:0] out;
  logic              out_valid;
  logic              out_ready;
  logic              dup_err;

  modport master (
    output in, sel, in_valid, flush, out_ready,
    input  in_ready, out, out_valid, dup_err
  );

  modport slave (
    input  in, sel, in_valid, flush, out_ready,
    output in_ready, out, out_valid, dup_err
  );
endinterface

// File: rtl/demux4_8.sv
// Reassembles two SIZE-bit halves, tagged by sel, into one 2*SIZE word.
// The word is held with a valid/ready handshake until it is consumed.
module demux4_8 #(
  parameter int SIZE = 4
) (
  input  logic       clk,
  input  logic       rst,
  demux4_8_if.slave  bus
);
  typedef enum logic [1:0] {
    EMPTY,
    HAVE_LO,
    HAVE_HI,
    FULL
  } state_t;

  state_t state;
  state_t state_nxt;
  logic   accept;
  logic   dup;

  assign bus.in_ready = !bus.flush &&
                        (state != FULL || bus.out_ready);
  assign accept = bus.in_valid && bus.in_ready;

  always_comb begin
    state_nxt = state;
    dup       = 1'b0;
    unique case (state)
      EMPTY: begin
        if (accept)
          state_nxt = bus.sel ? HAVE_HI : HAVE_LO;
      end
      HAVE_LO: begin
        if (bus.flush) begin
          state_nxt = EMPTY;
        end else if (accept) begin
          state_nxt = bus.sel ? FULL : HAVE_LO;
          dup       = !bus.sel;
        end
      end
      HAVE_HI: begin
        if (bus.flush) begin
          state_nxt = EMPTY;
        end else if (accept) begin
          state_nxt = bus.sel ? HAVE_HI : FULL;
          dup       = bus.sel;
        end
      end
      FULL: begin
        // Consume and refill on the same edge; the other half stays stale.
        if (bus.out_ready) begin
          if (accept)
            state_nxt = bus.sel ? HAVE_HI : HAVE_LO;
          else
            state_nxt = EMPTY;
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= EMPTY;
      bus.out       <= '0;
      bus.out_valid <= 1'b0;
      bus.dup_err   <= 1'b0;
    end else begin
      state         <= state_nxt;
      bus.out_valid <= (state_nxt == FULL);
      bus.dup_err   <= dup;
      if (accept) begin
        if (bus.sel)
          bus.out[2*SIZE-1:SIZE] <= bus.in;
        else
          bus.out[SIZE-1:0] <= bus.in;
      end
    end
  end
endmodule
